// File: rtl/pd_pkg.sv
// Shared constants, types and packet word map for the feature packer.
// Defines the snapshot record, FSM states and the word selector.
package pd_pkg;

  localparam int PKT_WORDS = 17;
  localparam int IDX_CHKSUM = PKT_WORDS - 1;
  localparam logic [15:0] HEADER_DEF = 16'hA55A;
  localparam int CNT_W_DEF = 16;

  localparam logic [4:0] W_HDR    = 5'd0;
  localparam logic [4:0] W_SEQ    = 5'd1;
  localparam logic [4:0] W_NUM    = 5'd2;
  localparam logic [4:0] W_PEAK   = 5'd3;
  localparam logic [4:0] W_FRONT  = 5'd4;
  localparam logic [4:0] W_BEHIND = 5'd5;
  localparam logic [4:0] W_TOTAL  = 5'd6;
  localparam logic [4:0] W_MEAN   = 5'd7;
  localparam logic [4:0] W_M2_HI  = 5'd8;
  localparam logic [4:0] W_M2_LO  = 5'd9;
  localparam logic [4:0] W_M3_HI  = 5'd10;
  localparam logic [4:0] W_M3_MI  = 5'd11;
  localparam logic [4:0] W_M3_LO  = 5'd12;
  localparam logic [4:0] W_M4_HI  = 5'd13;
  localparam logic [4:0] W_M4_MI  = 5'd14;
  localparam logic [4:0] W_M4_LO  = 5'd15;
  localparam logic [4:0] W_CHK    = 5'(IDX_CHKSUM);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] seq;
    logic [15:0] num;
    logic [7:0]  peak;
    logic [15:0] front;
    logic [15:0] behind;
    logic [15:0] total;
    logic [7:0]  mean;
    logic [7:0]  rem;
    logic [23:0] m2;
    logic [32:0] m3;
    logic [40:0] m4;
  } feat_t;

  function automatic logic [15:0] pkt_word(
    input feat_t       f,
    input logic [4:0]  i,
    input logic [15:0] hdr
  );
    logic [47:0] m3x;
    logic [47:0] m4x;
    logic [15:0] w;
    m3x = {{15{f.m3[32]}}, f.m3};
    m4x = {7'd0, f.m4};
    w = 16'h0000;
    unique case (i)
      W_HDR:    w = hdr;
      W_SEQ:    w = f.seq;
      W_NUM:    w = f.num;
      W_PEAK:   w = {8'h00, f.peak};
      W_FRONT:  w = f.front;
      W_BEHIND: w = f.behind;
      W_TOTAL:  w = f.total;
      W_MEAN:   w = {f.mean, f.rem};
      W_M2_HI:  w = {8'h00, f.m2[23:16]};
      W_M2_LO:  w = f.m2[15:0];
      W_M3_HI:  w = m3x[47:32];
      W_M3_MI:  w = m3x[31:16];
      W_M3_LO:  w = m3x[15:0];
      W_M4_HI:  w = m4x[47:32];
      W_M4_MI:  w = m4x[31:16];
      W_M4_LO:  w = m4x[15:0];
      default:  w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pd_feature_packer_if.sv
// Packet stream bundle: data, valid, ready, last.
// master drives the stream, slave is the host-link sink.
interface pd_feature_packer_if;
  logic [15:0] Pkt_data;
  logic        Pkt_valid;
  logic        Pkt_ready;
  logic        Pkt_last;

  modport master (
    output Pkt_data,
    output Pkt_valid,
    output Pkt_last,
    input  Pkt_ready
  );

  modport slave (
    input  Pkt_data,
    input  Pkt_valid,
    input  Pkt_last,
    output Pkt_ready
  );
endinterface

// File: rtl/pd_feature_snapshot.sv
// Two-slot register FIFO of feature snapshots.
// Ports: push/din write, pop frees dout slot, full/empty/count status.
module pd_feature_snapshot
  import pd_pkg::*;
(
  input  logic       Clk_arithmetic,
  input  logic       Rst,
  input  logic       push,
  input  logic       pop,
  input  feat_t      din,
  output feat_t      dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  feat_t      mem [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;

  // With both slots full wr==rd, so a push paired with a
  // pop lands in the slot being released at this edge.
  always_ff @(posedge Clk_arithmetic or negedge Rst) begin
    if (!Rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_q] <= din;
        wr_q      <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem[rd_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/pd_feature_packer.sv
// Snapshots pulse features on Over_flag and streams 17-word packets.
// Ports: feature inputs, pkt stream (master), Busy, Drop_cnt.
module pd_feature_packer
  import pd_pkg::*;
#(
  parameter logic [15:0] HEADER = HEADER_DEF,
  parameter int          CNT_W  = CNT_W_DEF
) (
  input  logic              Clk_arithmetic,
  input  logic              Rst,
  input  logic              Over_flag,
  input  logic [15:0]       Monopulse_num,
  input  logic [7:0]        Peak_value,
  input  logic [15:0]       Front_area,
  input  logic [15:0]       Behind_area,
  input  logic [15:0]       Total_area,
  input  logic [7:0]        Mean_value,
  input  logic [7:0]        Mean_value_remainders,
  input  logic [23:0]       Second_moment,
  input  logic [32:0]       Third_moment,
  input  logic [40:0]       Fourth_moment,
  pd_feature_packer_if.master pkt,
  output logic              Busy,
  output logic [CNT_W-1:0]  Drop_cnt
);

  state_t            state_q;
  state_t            state_d;
  logic [4:0]        idx_q;
  logic [4:0]        idx_d;
  logic [15:0]       acc_q;
  logic [15:0]       acc_d;
  logic [15:0]       data_q;
  logic [15:0]       data_d;
  logic              valid_q;
  logic              valid_d;
  logic              last_q;
  logic              last_d;
  logic [CNT_W-1:0]  seq_q;
  logic [CNT_W-1:0]  drop_q;

  feat_t       cap_f;
  feat_t       rd_f;
  logic        full;
  logic        empty;
  logic [1:0]  count;
  logic        accept;
  logic        pop;
  logic        push;
  logic        drop;
  logic [4:0]  idx_inc;
  logic [15:0] acc_inc;

  assign accept = valid_q && pkt.Pkt_ready;
  assign pop    = (state_q == SEND) && accept
                  && (idx_q == W_CHK);
  // A slot released this edge is free for capture.
  assign push   = Over_flag && (!full || pop);
  assign drop   = Over_flag && full && !pop;

  always_comb begin
    cap_f        = '0;
    cap_f.seq    = 16'(seq_q);
    cap_f.num    = Monopulse_num;
    cap_f.peak   = Peak_value;
    cap_f.front  = Front_area;
    cap_f.behind = Behind_area;
    cap_f.total  = Total_area;
    cap_f.mean   = Mean_value;
    cap_f.rem    = Mean_value_remainders;
    cap_f.m2     = Second_moment;
    cap_f.m3     = Third_moment;
    cap_f.m4     = Fourth_moment;
  end

  pd_feature_snapshot u_snap (
    .Clk_arithmetic (Clk_arithmetic),
    .Rst            (Rst),
    .push           (push),
    .pop            (pop),
    .din            (cap_f),
    .dout           (rd_f),
    .full           (full),
    .empty          (empty),
    .count          (count)
  );

  always_ff @(posedge Clk_arithmetic or negedge Rst) begin
    if (!Rst) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push && (seq_q != '1)) begin
        seq_q <= seq_q + 1'b1;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_arithmetic or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (pop && (count == 2'd1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_inc = idx_q + 5'd1;
  assign acc_inc = acc_q + data_q;

  // acc holds the sum of words already accepted, so the
  // checksum word is ready when word 15 is accepted.
  always_comb begin
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          idx_d   = W_HDR;
          acc_d   = 16'h0000;
          data_d  = HEADER;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_q == W_CHK) begin
            idx_d  = W_HDR;
            acc_d  = 16'h0000;
            last_d = 1'b0;
            if (count == 2'd1) begin
              valid_d = 1'b0;
            end else begin
              data_d = HEADER;
            end
          end else begin
            idx_d  = idx_inc;
            acc_d  = acc_inc;
            last_d = (idx_inc == W_CHK);
            data_d = (idx_inc == W_CHK) ? acc_inc
                     : pkt_word(rd_f, idx_inc, HEADER);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_arithmetic or negedge Rst) begin
    if (!Rst) begin
      idx_q   <= 5'd0;
      acc_q   <= 16'h0000;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign pkt.Pkt_data  = data_q;
  assign pkt.Pkt_valid = valid_q;
  assign pkt.Pkt_last  = last_q;
  assign Busy          = !empty;
  assign Drop_cnt      = drop_q;

endmodule
